// File: rtl/matcher_result_collector_if.sv
// Filter result bus, record stream and window status seen by the matcher result collector.
// master = filter/readout environment, slave = collector.
interface matcher_result_collector_if #(
  parameter int INPUT_STREAM_WIDTH = 512,
  parameter int DATA_WIDTH         = 24,
  parameter int COUNT_WIDTH        = 16
);
  localparam int MASK_W   = INPUT_STREAM_WIDTH / 8;
  localparam int OFFSET_W = $clog2(MASK_W);

  logic [MASK_W-1:0]      filter_result;
  logic [DATA_WIDTH-1:0]  filter_result_data;
  logic                   filter_result_valid;
  logic                   filter_result_done;
  logic                   filter_result_reset;

  logic                   rec_valid;
  logic                   rec_ready;
  logic [OFFSET_W-1:0]    rec_offset;
  logic [DATA_WIDTH-1:0]  rec_data;

  logic                   window_done;
  logic [COUNT_WIDTH-1:0] window_count;
  logic                   busy;

  modport master (
    output filter_result, filter_result_data, filter_result_valid, filter_result_done,
    output rec_ready,
    input  filter_result_reset, rec_valid, rec_offset, rec_data,
    input  window_done, window_count, busy
  );

  modport slave (
    input  filter_result, filter_result_data, filter_result_valid, filter_result_done,
    input  rec_ready,
    output filter_result_reset, rec_valid, rec_offset, rec_data,
    output window_done, window_count, busy
  );
endinterface

// File: rtl/matcher_result_collector.sv
// Serialises filter hit masks into (offset, entry) records through a show-ahead FIFO
// and reports a per-window match count when the filter signals list exhaustion.
//
// state    | meaning
// IDLE     | waiting for a filter result or end of window
// SCAN     | pushing one record per set mask bit, lowest offset first
// ACK      | filter_result_reset high for this cycle
// WAIT_LOW | holding until the filter drops valid
// DRAIN    | waiting for FIFO empty, then one window_done per done level
module matcher_result_collector #(
  parameter int INPUT_STREAM_WIDTH = 512,
  parameter int DATA_WIDTH         = 24,
  parameter int FIFO_DEPTH         = 16,
  parameter int COUNT_WIDTH        = 16
) (
  input logic fclk,
  input logic areset,
  matcher_result_collector_if.slave bus
);
  localparam int MASK_W   = INPUT_STREAM_WIDTH / 8;
  localparam int OFFSET_W = $clog2(MASK_W);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int REC_W    = OFFSET_W + DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, SCAN, ACK, WAIT_LOW, DRAIN} state_t;

  state_t                 state;
  logic [MASK_W-1:0]      mask;
  logic [DATA_WIDTH-1:0]  data;
  logic [COUNT_WIDTH-1:0] match_cnt;
  logic                   reported;
  logic                   window_done_r;
  logic [COUNT_WIDTH-1:0] window_count_r;

  logic [REC_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [REC_W-1:0]       head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [OFFSET_W-1:0]    low_idx;

  // Descending scan so the last hit written is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = OFFSET_W'(i);
    end
  end

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  // Push is gated on the registered count only, so a same-cycle pop never frees a slot.
  assign push       = (state == SCAN) && (mask != '0) && !fifo_full;
  assign pop        = !fifo_empty && bus.rec_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge fclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge fclk) begin
    if (push) mem[wr_ptr] <= {low_idx, data};
  end

  always_ff @(posedge fclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      mask           <= '0;
      data           <= '0;
      match_cnt      <= '0;
      reported       <= 1'b0;
      window_done_r  <= 1'b0;
      window_count_r <= '0;
    end else begin
      window_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.filter_result_valid) begin
            mask  <= bus.filter_result;
            data  <= bus.filter_result_data;
            state <= SCAN;
          end else if (bus.filter_result_done) begin
            reported <= 1'b0;
            state    <= DRAIN;
          end
        end
        SCAN: begin
          if (mask == '0) begin
            state <= ACK;
          end else if (push) begin
            mask <= mask & (mask - 1'b1);
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
          end
        end
        ACK: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!bus.filter_result_valid) state <= IDLE;
        end
        DRAIN: begin
          if (fifo_empty) begin
            if (!reported) begin
              window_done_r  <= 1'b1;
              window_count_r <= match_cnt;
              match_cnt      <= '0;
              reported       <= 1'b1;
            end
            if (!bus.filter_result_done) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.filter_result_reset = (state == ACK);
  assign bus.busy                = (state != IDLE);
  assign bus.window_done         = window_done_r;
  assign bus.window_count        = window_count_r;
  assign bus.rec_valid           = !fifo_empty;
  // Head is masked to zero while empty so the outputs read 0 out of reset.
  assign bus.rec_offset          = fifo_empty ? '0 : head[REC_W-1:DATA_WIDTH];
  assign bus.rec_data            = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_matcher_result_collector.sv
// Directed bench for matcher_result_collector: record order, ack timing, backpressure,
// window reporting and asynchronous reset.
module tb_matcher_result_collector;
  localparam int ISW = 512;
  localparam int DW  = 24;
  localparam int FD  = 16;
  localparam int CW  = 16;

  logic fclk   = 1'b0;
  logic areset = 1'b1;

  matcher_result_collector_if #(.INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  matcher_result_collector #(
    .INPUT_STREAM_WIDTH(ISW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)
  ) dut (
    .fclk   (fclk),
    .areset (areset),
    .bus    (bus)
  );

  initial forever #5 fclk = ~fclk;

  typedef struct packed {
    logic [5:0]  off;
    logic [23:0] dat;
  } rec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   ack_cnt  = 0;
  int   wd_cnt   = 0;
  int   cmp_idx  = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t held;
  logic hold_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Observes the record stream and pulses mid-cycle, where inputs and outputs are settled.
  initial forever begin
    @(negedge fclk);
    if (bus.filter_result_reset) ack_cnt++;
    if (bus.window_done) wd_cnt++;
    if (hold_pend && bus.rec_valid)
      check("head_stable", 64'({bus.rec_offset, bus.rec_data}), 64'(held));
    hold_pend = bus.rec_valid && !bus.rec_ready;
    held      = rec_t'({bus.rec_offset, bus.rec_data});
    if (bus.rec_valid && bus.rec_ready)
      got_q.push_back(rec_t'({bus.rec_offset, bus.rec_data}));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((bus.busy || bus.rec_valid) && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.busy || bus.rec_valid), 64'(0));
  endtask

  task automatic send_result(input logic [63:0] m, input logic [23:0] d,
                             input int hold, output int ack_cyc);
    int c = 1;
    int n = 0;
    bus.filter_result       = m;
    bus.filter_result_data  = d;
    bus.filter_result_valid = 1'b1;
    tick();
    ack_cyc = 0;
    while (!bus.filter_result_reset && c < 300) begin
      tick();
      c++;
    end
    if (bus.filter_result_reset) ack_cyc = c;
    repeat (hold) tick();
    if (hold > 0) begin
      check("wait_low_busy", 64'(bus.busy), 64'(1));
      check("wait_low_no_ack", 64'(bus.filter_result_reset), 64'(0));
    end
    bus.filter_result_valid = 1'b0;
    bus.filter_result       = '0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check("idle_after_ack", 64'(bus.busy), 64'(0));
  endtask

  task automatic close_window(input int hold_cycles, input logic [CW-1:0] exp_cnt, input string tag);
    int wd0 = wd_cnt;
    bus.filter_result_done = 1'b1;
    repeat (hold_cycles) tick();
    bus.filter_result_done = 1'b0;
    wait_quiet({tag, "_quiet"});
    tick();
    tick();
    check({tag, "_pulses"}, 64'(wd_cnt - wd0), 64'(1));
    check({tag, "_count"}, 64'(bus.window_count), 64'(exp_cnt));
  endtask

  task automatic check_records(input string tag);
    check({tag, "_nrec"}, 64'(got_q.size() - cmp_idx), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (cmp_idx + i < got_q.size())
        check($sformatf("%s_rec%0d", tag, i), 64'(got_q[cmp_idx + i]), 64'(exp_q[i]));
    end
    cmp_idx = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int ac;
    int a0;
    bus.filter_result       = '0;
    bus.filter_result_data  = '0;
    bus.filter_result_valid = 1'b0;
    bus.filter_result_done  = 1'b0;
    bus.rec_ready           = 1'b0;

    tick();
    tick();
    check("rst_rec_valid", 64'(bus.rec_valid), 64'(0));
    check("rst_fr_reset", 64'(bus.filter_result_reset), 64'(0));
    check("rst_rec_offset", 64'(bus.rec_offset), 64'(0));
    check("rst_rec_data", 64'(bus.rec_data), 64'(0));
    check("rst_window_done", 64'(bus.window_done), 64'(0));
    check("rst_window_count", 64'(bus.window_count), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    areset = 1'b0;
    tick();

    // Three hits, unstalled: ack lands in the 5th cycle after the capture edge.
    bus.rec_ready = 1'b1;
    a0 = ack_cnt;
    send_result(64'h105, 24'hABCDEF, 0, ac);
    check("t1_ack_cycle", 64'(ac), 64'(5));
    wait_quiet("t1_quiet");
    tick();
    check("t1_ack_count", 64'(ack_cnt - a0), 64'(1));
    exp_q.push_back(rec_t'({6'd0, 24'hABCDEF}));
    exp_q.push_back(rec_t'({6'd2, 24'hABCDEF}));
    exp_q.push_back(rec_t'({6'd8, 24'hABCDEF}));
    check_records("t1");
    close_window(1, 16'd3, "t1_close");

    // Two results, the first holding valid through WAIT_LOW.
    a0 = ack_cnt;
    send_result(64'h1, 24'h111111, 3, ac);
    send_result(64'h8000_0000_0000_0000, 24'h222222, 0, ac);
    check("t2_ack_cycle", 64'(ac), 64'(3));
    wait_quiet("t2_quiet");
    tick();
    check("t2_ack_count", 64'(ack_cnt - a0), 64'(2));
    exp_q.push_back(rec_t'({6'd0, 24'h111111}));
    exp_q.push_back(rec_t'({6'd63, 24'h222222}));
    check_records("t2");
    close_window(1, 16'd2, "t2_close");

    // Zero mask: one SCAN cycle, no record.
    send_result(64'h0, 24'h333333, 0, ac);
    check("t0_ack_cycle", 64'(ac), 64'(2));
    tick();
    check_records("t0");

    // 20 hits into a 16-deep FIFO with the consumer stalled.
    bus.rec_ready = 1'b0;
    a0 = ack_cnt;
    bus.filter_result       = 64'h0000_00AA_AAAA_AAAA;
    bus.filter_result_data  = 24'h5A5A5A;
    bus.filter_result_valid = 1'b1;
    tick();
    bus.filter_result_valid = 1'b0;
    bus.filter_result       = '0;
    repeat (22) tick();
    check("t3_stall_busy", 64'(bus.busy), 64'(1));
    check("t3_stall_no_ack", 64'(ack_cnt - a0), 64'(0));
    check("t3_head_offset", 64'(bus.rec_offset), 64'(1));
    bus.rec_ready = 1'b1;
    wait_quiet("t3_quiet");
    tick();
    check("t3_ack_count", 64'(ack_cnt - a0), 64'(1));
    for (int i = 0; i < 20; i++) exp_q.push_back(rec_t'({6'(2 * i + 1), 24'h5A5A5A}));
    check_records("t3");

    // Consumer toggling ready every cycle.
    a0 = ack_cnt;
    bus.rec_ready           = 1'b0;
    bus.filter_result       = 64'h0000_0000_F000_000F;
    bus.filter_result_data  = 24'h123456;
    bus.filter_result_valid = 1'b1;
    tick();
    bus.filter_result_valid = 1'b0;
    bus.filter_result       = '0;
    for (int n = 0; n < 80 && (bus.busy || bus.rec_valid); n++) begin
      bus.rec_ready = ~bus.rec_ready;
      tick();
    end
    check("t4_quiet", 64'(bus.busy || bus.rec_valid), 64'(0));
    tick();
    check("t4_ack_count", 64'(ack_cnt - a0), 64'(1));
    exp_q.push_back(rec_t'({6'd0, 24'h123456}));
    exp_q.push_back(rec_t'({6'd1, 24'h123456}));
    exp_q.push_back(rec_t'({6'd2, 24'h123456}));
    exp_q.push_back(rec_t'({6'd3, 24'h123456}));
    exp_q.push_back(rec_t'({6'd28, 24'h123456}));
    exp_q.push_back(rec_t'({6'd29, 24'h123456}));
    exp_q.push_back(rec_t'({6'd30, 24'h123456}));
    exp_q.push_back(rec_t'({6'd31, 24'h123456}));
    check_records("t4");
    bus.rec_ready = 1'b1;
    close_window(1, 16'd28, "t34_close");

    // Done held 10 cycles while 3 records are still queued.
    bus.rec_ready = 1'b0;
    send_result(64'h0000_0000_0001_0030, 24'h0F0F0F, 0, ac);
    check("t5_fifo_held", 64'(bus.rec_valid), 64'(1));
    bus.rec_ready = 1'b1;
    close_window(10, 16'd3, "t5_close");
    exp_q.push_back(rec_t'({6'd4, 24'h0F0F0F}));
    exp_q.push_back(rec_t'({6'd5, 24'h0F0F0F}));
    exp_q.push_back(rec_t'({6'd16, 24'h0F0F0F}));
    check_records("t5");
    close_window(1, 16'd0, "t5_cleared");

    // Asynchronous reset in SCAN with 4 records queued.
    bus.rec_ready           = 1'b0;
    bus.filter_result       = 64'h3F;
    bus.filter_result_data  = 24'h777777;
    bus.filter_result_valid = 1'b1;
    tick();
    bus.filter_result_valid = 1'b0;
    bus.filter_result       = '0;
    repeat (4) tick();
    check("t6_pre_busy", 64'(bus.busy), 64'(1));
    check("t6_pre_rec_valid", 64'(bus.rec_valid), 64'(1));
    #2;
    areset = 1'b1;
    #1;
    check("t6_rst_rec_valid", 64'(bus.rec_valid), 64'(0));
    check("t6_rst_fr_reset", 64'(bus.filter_result_reset), 64'(0));
    check("t6_rst_busy", 64'(bus.busy), 64'(0));
    check("t6_rst_rec_offset", 64'(bus.rec_offset), 64'(0));
    tick();
    areset = 1'b0;
    a0 = ack_cnt;
    repeat (3) tick();
    check("t6_no_ack", 64'(ack_cnt - a0), 64'(0));
    check("t6_idle", 64'(bus.busy), 64'(0));
    bus.rec_ready = 1'b1;
    send_result(64'h4, 24'h888888, 0, ac);
    wait_quiet("t6_quiet");
    tick();
    exp_q.push_back(rec_t'({6'd2, 24'h888888}));
    check_records("t6");
    close_window(1, 16'd1, "t6_close");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
